// File: rtl/top_pkg.sv
// Shared definitions for the CSI-2 receive packet sequencer: data type codes,
// the packet FSM state enum, lane count and packet-header field positions.
package top_pkg;

   localparam int NUM_LANE = 2;
   localparam int WORD_W   = NUM_LANE * 16;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_RAW12 = 6'h2C;

   localparam int HDR_DT_LSB  = 0;
   localparam int HDR_DT_MSB  = 5;
   localparam int HDR_VC_LSB  = 6;
   localparam int HDR_VC_MSB  = 7;
   localparam int HDR_WC_LSB  = 8;
   localparam int HDR_WC_MSB  = 23;
   localparam int HDR_ECC_LSB = 24;
   localparam int HDR_ECC_MSB = 31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAYLOAD,
      ST_TAIL,
      ST_SKIP
   } rx_state_t;

endpackage

// File: rtl/csi_rx_hdr_ecc.sv
// Combinational MIPI packet-header ECC generator: 24 header bits in, 6 parity
// bits out. Each parity bit is the XOR of a fixed subset of header bits.
module csi_rx_hdr_ecc (
   input  logic [23:0] hdr,
   output logic [5:0]  ecc
);

   localparam logic [23:0] MASK_P0 = 24'hF12CB7;
   localparam logic [23:0] MASK_P1 = 24'hF2555B;
   localparam logic [23:0] MASK_P2 = 24'h749A6D;
   localparam logic [23:0] MASK_P3 = 24'hB8E38E;
   localparam logic [23:0] MASK_P4 = 24'hDF03F0;
   localparam logic [23:0] MASK_P5 = 24'hEFFC00;

   // Reduce each masked header to one parity bit
   always_comb begin
      ecc[0] = ^(hdr & MASK_P0);
      ecc[1] = ^(hdr & MASK_P1);
      ecc[2] = ^(hdr & MASK_P2);
      ecc[3] = ^(hdr & MASK_P3);
      ecc[4] = ^(hdr & MASK_P4);
      ecc[5] = ^(hdr & MASK_P5);
   end

endmodule

// File: rtl/csi_rx_packet_ctrl.sv
// Packet-level sequencer between the lane word aligner and the RAW12 unpacker.
// Parses burst headers, tracks frame/line state from short packets, forwards
// payload words of accepted long packets and holds the unpacker enabled for a
// few cycles after frame end so its pipeline drains.
// Optional feature: define CSI_RX_ECC_CHECK_EN to check the header ECC and
// discard bursts whose header fails it (hdr_err). Without it the ECC byte is
// ignored and hdr_err stays 0.
module csi_rx_packet_ctrl
   import top_pkg::*;
#(
   parameter logic [5:0] DATA_TYPE = DT_RAW12,
   parameter logic [1:0] VC        = 2'd0,
   parameter int         DRAIN_CYC = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] data_in,
   input  logic              din_valid,
   output logic [WORD_W-1:0] payload_data,
   output logic              payload_valid,
   output logic              unpack_enable,
   output logic              in_frame,
   output logic              frame_start,
   output logic              frame_end,
   output logic              line_start,
   output logic [15:0]       line_count,
   output logic [15:0]       word_count,
   output logic              hdr_err,
   output logic              len_err,
   output logic              trunc_err
);

   localparam int DRAIN_W = $clog2(DRAIN_CYC + 2);

   rx_state_t          state;
   logic [13:0]        words_left;
   logic [DRAIN_W-1:0] drain_cnt;

   logic [5:0]         hdr_dt;
   logic [1:0]         hdr_vc;
   logic [15:0]        hdr_wc;
   logic               hdr_ok;
   logic               unused_hdr_bits;

   logic               hdr_take;
   logic               hdr_accept;
   logic               accept_fs;
   logic               accept_fe;
   logic               is_long;
   logic               good_len;
   logic               accept_long;
   logic               bad_len;
   logic               in_frame_nxt;
   logic [DRAIN_W-1:0] drain_nxt;

   assign hdr_dt = data_in[HDR_DT_MSB:HDR_DT_LSB];
   assign hdr_vc = data_in[HDR_VC_MSB:HDR_VC_LSB];
   assign hdr_wc = data_in[HDR_WC_MSB:HDR_WC_LSB];

`ifdef CSI_RX_ECC_CHECK_EN
   logic [5:0] ecc_calc;

   csi_rx_hdr_ecc u_hdr_ecc (
      .hdr (data_in[HDR_WC_MSB:0]),
      .ecc (ecc_calc)
   );

   assign hdr_ok          = (ecc_calc == data_in[HDR_ECC_LSB+5:HDR_ECC_LSB]);
   assign unused_hdr_bits = ^data_in[HDR_ECC_MSB:HDR_ECC_LSB+6];
`else
   assign hdr_ok          = 1'b1;
   assign unused_hdr_bits = ^data_in[HDR_ECC_MSB:HDR_ECC_LSB];
`endif

   // Classify the header word seen in IDLE and work out next frame/drain state
   always_comb begin
      hdr_take     = (state == ST_IDLE) && din_valid;
      hdr_accept   = hdr_take && hdr_ok && (hdr_vc == VC);
      accept_fs    = hdr_accept && (hdr_dt == DT_FS);
      accept_fe    = hdr_accept && (hdr_dt == DT_FE);
      is_long      = hdr_accept && !accept_fs && !accept_fe && (hdr_dt == DATA_TYPE);
      good_len     = (hdr_wc != 16'd0) && (hdr_wc[1:0] == 2'b00);
      accept_long  = is_long && good_len;
      bad_len      = is_long && !good_len;
      in_frame_nxt = in_frame;
      if (accept_fs) begin
         in_frame_nxt = 1'b1;
      end else if (accept_fe) begin
         in_frame_nxt = 1'b0;
      end
      drain_nxt = drain_cnt;
      if (accept_fe) begin
         drain_nxt = DRAIN_W'(DRAIN_CYC);
      end else if (drain_cnt != '0) begin
         drain_nxt = drain_cnt - DRAIN_W'(1);
      end
   end

   // Packet FSM with all outputs registered
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         words_left    <= '0;
         drain_cnt     <= '0;
         payload_data  <= '0;
         payload_valid <= 1'b0;
         unpack_enable <= 1'b0;
         in_frame      <= 1'b0;
         frame_start   <= 1'b0;
         frame_end     <= 1'b0;
         line_start    <= 1'b0;
         line_count    <= '0;
         word_count    <= '0;
         hdr_err       <= 1'b0;
         len_err       <= 1'b0;
         trunc_err     <= 1'b0;
      end else begin
         in_frame      <= in_frame_nxt;
         drain_cnt     <= drain_nxt;
         unpack_enable <= in_frame_nxt || (drain_nxt != '0);
         frame_start   <= accept_fs;
         frame_end     <= accept_fe;
         line_start    <= accept_long;
         len_err       <= bad_len;
         hdr_err       <= hdr_take && !hdr_ok;
         trunc_err     <= (state == ST_PAYLOAD) && !din_valid;
         payload_valid <= (state == ST_PAYLOAD) && din_valid;

         if (accept_fs) begin
            line_count <= '0;
         end else if (accept_long && (line_count != 16'hFFFF)) begin
            line_count <= line_count + 16'd1;
         end

         if (accept_long) begin
            word_count <= hdr_wc;
            words_left <= hdr_wc[15:2];
         end

         case (state)
            ST_IDLE: begin
               if (din_valid) begin
                  if (accept_fs || accept_fe) begin
                     state <= ST_TAIL;
                  end else if (accept_long) begin
                     state <= ST_PAYLOAD;
                  end else begin
                     state <= ST_SKIP;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (din_valid) begin
                  payload_data <= data_in;
                  words_left   <= words_left - 14'd1;
                  if (words_left == 14'd1) begin
                     state <= ST_TAIL;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_TAIL, ST_SKIP: begin
               if (!din_valid) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csi_rx_packet_ctrl.sv
// Self-checking bench for csi_rx_packet_ctrl: directed bursts followed by
// randomized bursts, each predicted by a packet-level model of frame/line rules.
module tb_csi_rx_packet_ctrl;

   localparam int DRAIN = 4;
   localparam int GAP   = DRAIN + 3;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        din_valid;
   logic [31:0] payload_data;
   logic        payload_valid;
   logic        unpack_enable;
   logic        in_frame;
   logic        frame_start;
   logic        frame_end;
   logic        line_start;
   logic [15:0] line_count;
   logic [15:0] word_count;
   logic        hdr_err;
   logic        len_err;
   logic        trunc_err;

   csi_rx_packet_ctrl dut (
      .clock         (clock),
      .reset         (reset),
      .data_in       (data_in),
      .din_valid     (din_valid),
      .payload_data  (payload_data),
      .payload_valid (payload_valid),
      .unpack_enable (unpack_enable),
      .in_frame      (in_frame),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .line_start    (line_start),
      .line_count    (line_count),
      .word_count    (word_count),
      .hdr_err       (hdr_err),
      .len_err       (len_err),
      .trunc_err     (trunc_err)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int fs_n = 0, fe_n = 0, ls_n = 0, hdr_n = 0, len_n = 0, tr_n = 0;
   int fs_cyc = -1, fe_cyc = -1, ls_cyc = -1, ue_fall_cyc = -1;
   logic ue_prev = 1'b0;
   logic [31:0] pv_data[$];
   int          pv_cyc[$];

   logic [31:0] burst_words[$];
   int m_in_frame, m_line, m_wc;

   // Record pulses, payload words and enable falls one step after each edge
   always @(posedge clock) begin
      #1;
      cyc++;
      if (frame_start) begin fs_n++; fs_cyc = cyc; end
      if (frame_end)   begin fe_n++; fe_cyc = cyc; end
      if (line_start)  begin ls_n++; ls_cyc = cyc; end
      if (hdr_err)     hdr_n++;
      if (len_err)     len_n++;
      if (trunc_err)   tr_n++;
      if (payload_valid) begin
         pv_data.push_back(payload_data);
         pv_cyc.push_back(cyc);
      end
      if (ue_prev && !unpack_enable) ue_fall_cyc = cyc;
      ue_prev = unpack_enable;
   end

`ifdef CSI_RX_ECC_CHECK_EN
   function automatic logic [5:0] eccOf(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction
`endif

   function automatic logic [31:0] mkHdr(input logic [5:0] dt, input logic [1:0] vc,
                                         input logic [15:0] wc);
      logic [23:0] h;
      h = {wc, vc, dt};
`ifdef CSI_RX_ECC_CHECK_EN
      return {2'b00, eccOf(h), h};
`else
      return {8'($urandom), h};
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_payload_data"}, payload_data, 0);
      checkOutput({tag, "_payload_valid"}, payload_valid, 0);
      checkOutput({tag, "_unpack_enable"}, unpack_enable, 0);
      checkOutput({tag, "_in_frame"}, in_frame, 0);
      checkOutput({tag, "_pulses"}, {frame_start, frame_end, line_start, hdr_err, len_err, trunc_err}, 0);
      checkOutput({tag, "_line_count"}, line_count, 0);
      checkOutput({tag, "_word_count"}, word_count, 0);
   endtask

   // Drive one burst: header, n_after following words, then an idle gap
   task automatic applyStimulus(input logic [31:0] hdr, input int n_after, output int c0);
      burst_words.delete();
      @(negedge clock);
      c0        = cyc;
      din_valid = 1'b1;
      data_in   = hdr;
      for (int i = 0; i < n_after; i++) begin
         @(negedge clock);
         data_in = $urandom;
         burst_words.push_back(data_in);
      end
      @(negedge clock);
      din_valid = 1'b0;
      data_in   = $urandom;
      repeat (GAP) @(negedge clock);
   endtask

   // Send a burst, predict its effect from packet rules, and check everything
   task automatic sendAndCheck(input string tag, input logic [31:0] hdr, input int n_after,
                               input bit ecc_bad);
      int fs0, fe0, ls0, hd0, ln0, tr0, base, c0;
      int e_fs, e_fe, e_ls, e_hdr, e_len, e_tr, e_pay, npay, got;
      int dt, vc, wc;
      fs0 = fs_n; fe0 = fe_n; ls0 = ls_n; hd0 = hdr_n; ln0 = len_n; tr0 = tr_n;
      base = pv_data.size();
      applyStimulus(hdr, n_after, c0);

      dt = int'(hdr[5:0]);
      vc = int'(hdr[7:6]);
      wc = int'(hdr[23:8]);
      e_fs = 0; e_fe = 0; e_ls = 0; e_hdr = 0; e_len = 0; e_tr = 0; e_pay = 0;
      if (ecc_bad) begin
         e_hdr = 1;
      end else if (vc != 0) begin
         e_pay = 0;
      end else if (dt == 'h00) begin
         e_fs = 1; m_in_frame = 1; m_line = 0;
      end else if (dt == 'h01) begin
         e_fe = 1; m_in_frame = 0;
      end else if (dt == 'h2C) begin
         if (wc != 0 && wc % 4 == 0) begin
            e_ls = 1;
            m_wc = wc;
            if (m_line < 65535) m_line = m_line + 1;
            npay = wc / 4;
            if (n_after < npay) begin
               e_tr  = 1;
               e_pay = n_after;
            end else begin
               e_pay = npay;
            end
         end else begin
            e_len = 1;
         end
      end

      got = pv_data.size() - base;
      checkOutput({tag, ":frame_start"}, fs_n - fs0, e_fs);
      checkOutput({tag, ":frame_end"}, fe_n - fe0, e_fe);
      checkOutput({tag, ":line_start"}, ls_n - ls0, e_ls);
      checkOutput({tag, ":hdr_err"}, hdr_n - hd0, e_hdr);
      checkOutput({tag, ":len_err"}, len_n - ln0, e_len);
      checkOutput({tag, ":trunc_err"}, tr_n - tr0, e_tr);
      checkOutput({tag, ":payload_count"}, got, e_pay);
      for (int i = 0; i < e_pay && i < got; i++) begin
         checkOutput({tag, ":payload_data"}, pv_data[base + i], burst_words[i]);
      end
      if (e_pay > 0 && got >= e_pay) begin
         checkOutput({tag, ":payload_first_cyc"}, pv_cyc[base], c0 + 2);
         checkOutput({tag, ":payload_last_cyc"}, pv_cyc[base + e_pay - 1], c0 + 1 + e_pay);
      end
      if (e_fs == 1) checkOutput({tag, ":fs_latency"}, fs_cyc, c0 + 1);
      if (e_ls == 1) checkOutput({tag, ":ls_latency"}, ls_cyc, c0 + 1);
      if (e_fe == 1) begin
         checkOutput({tag, ":fe_latency"}, fe_cyc, c0 + 1);
         checkOutput({tag, ":enable_fall"}, ue_fall_cyc, fe_cyc + DRAIN);
      end
      checkOutput({tag, ":in_frame"}, in_frame, m_in_frame);
      checkOutput({tag, ":unpack_enable"}, unpack_enable, m_in_frame);
      checkOutput({tag, ":line_count"}, line_count, m_line);
      checkOutput({tag, ":word_count"}, word_count, m_wc);
   endtask

   // Directed scenarios, then randomized bursts
   initial begin
      int c0, c1, base, fs0, ls0;
      logic [31:0] w0, w1;
      reset     = 1'b1;
      din_valid = 1'b0;
      data_in   = '0;
      m_in_frame = 0; m_line = 0; m_wc = 0;
      repeat (3) @(negedge clock);
      checkAllZero("reset");
      reset = 1'b0;

      sendAndCheck("fs", mkHdr(6'h00, 2'd0, 16'd0), 0, 1'b0);
      sendAndCheck("raw12", mkHdr(6'h2C, 2'd0, 16'd12), 4, 1'b0);
      checkOutput("raw12_line_count_1", line_count, 1);
      checkOutput("raw12_word_count_12", word_count, 12);
      sendAndCheck("fe", mkHdr(6'h01, 2'd0, 16'd0), 0, 1'b0);
      sendAndCheck("fs2", mkHdr(6'h00, 2'd0, 16'd0), 1, 1'b0);
      sendAndCheck("len10", mkHdr(6'h2C, 2'd0, 16'd10), 3, 1'b0);
      sendAndCheck("len0", mkHdr(6'h2C, 2'd0, 16'd0), 1, 1'b0);
      sendAndCheck("trunc", mkHdr(6'h2C, 2'd0, 16'd16), 2, 1'b0);
      sendAndCheck("after_trunc", mkHdr(6'h2C, 2'd0, 16'd8), 3, 1'b0);
      sendAndCheck("vc1", mkHdr(6'h2C, 2'd1, 16'd8), 3, 1'b0);
      sendAndCheck("other_dt", mkHdr(6'h12, 2'd0, 16'd8), 3, 1'b0);

`ifdef CSI_RX_ECC_CHECK_EN
      sendAndCheck("ecc_fe", mkHdr(6'h01, 2'd0, 16'd0), 0, 1'b0);
      sendAndCheck("ecc_bad_fs", mkHdr(6'h00, 2'd0, 16'd0) ^ (32'h1 << (24 + $urandom_range(0, 5))),
                   0, 1'b1);
      sendAndCheck("ecc_good_fs", mkHdr(6'h00, 2'd0, 16'd0), 0, 1'b0);
`endif

      // FS burst, then a RAW12 header the cycle right after din_valid falls
      fs0 = fs_n; ls0 = ls_n;
      @(negedge clock); din_valid = 1'b1; data_in = mkHdr(6'h00, 2'd0, 16'd0); c0 = cyc;
      @(negedge clock); data_in = $urandom;
      @(negedge clock); din_valid = 1'b0;
      @(negedge clock); din_valid = 1'b1; data_in = mkHdr(6'h2C, 2'd0, 16'd8); c1 = cyc;
      base = pv_data.size();
      @(negedge clock); data_in = $urandom; w0 = data_in;
      @(negedge clock); data_in = $urandom; w1 = data_in;
      @(negedge clock); data_in = $urandom;
      @(negedge clock); din_valid = 1'b0;
      repeat (GAP) @(negedge clock);
      m_in_frame = 1; m_line = 1; m_wc = 8;
      checkOutput("b2b_fs_count", fs_n - fs0, 1);
      checkOutput("b2b_fs_latency", fs_cyc, c0 + 1);
      checkOutput("b2b_ls_count", ls_n - ls0, 1);
      checkOutput("b2b_ls_latency", ls_cyc, c1 + 1);
      checkOutput("b2b_payload_count", pv_data.size() - base, 2);
      if (pv_data.size() >= base + 2) begin
         checkOutput("b2b_payload0", pv_data[base], w0);
         checkOutput("b2b_payload1", pv_data[base + 1], w1);
      end
      checkOutput("b2b_line_count", line_count, m_line);
      checkOutput("b2b_in_frame", in_frame, m_in_frame);

      // Reset in the middle of a payload
      @(negedge clock); din_valid = 1'b1; data_in = mkHdr(6'h2C, 2'd0, 16'd16);
      @(negedge clock); data_in = $urandom;
      @(negedge clock); data_in = $urandom;
      @(negedge clock); data_in = $urandom; reset = 1'b1;
      @(posedge clock); #1;
      checkAllZero("mid_reset");
      @(negedge clock); reset = 1'b0; din_valid = 1'b0;
      m_in_frame = 0; m_line = 0; m_wc = 0;
      repeat (3) @(negedge clock);
      sendAndCheck("post_reset_fs", mkHdr(6'h00, 2'd0, 16'd0), 0, 1'b0);
      sendAndCheck("post_reset_line", mkHdr(6'h2C, 2'd0, 16'd8), 3, 1'b0);

      for (int k = 0; k < 60; k++) begin
         int kind, np, vc;
         logic [15:0] wc;
         logic [5:0]  dt;
         kind = $urandom_range(0, 9);
         case (kind)
            0: sendAndCheck("rnd_fs", mkHdr(6'h00, 2'd0, 16'd0), $urandom_range(0, 2), 1'b0);
            1: sendAndCheck("rnd_fe", mkHdr(6'h01, 2'd0, 16'd0), $urandom_range(0, 2), 1'b0);
            6: begin
               wc = 16'($urandom_range(1, 120));
               if (wc[1:0] == 2'b00) wc = wc + 16'd1;
               if ($urandom_range(0, 3) == 0) wc = 16'd0;
               sendAndCheck("rnd_badlen", mkHdr(6'h2C, 2'd0, wc), $urandom_range(0, 3), 1'b0);
            end
            7: begin
               np = $urandom_range(2, 6);
               sendAndCheck("rnd_trunc", mkHdr(6'h2C, 2'd0, 16'(np * 4)),
                            $urandom_range(0, np - 1), 1'b0);
            end
            8: begin
               vc = $urandom_range(1, 3);
               case ($urandom_range(0, 2))
                  0:       dt = 6'h00;
                  1:       dt = 6'h01;
                  default: dt = 6'h2C;
               endcase
               sendAndCheck("rnd_othervc", mkHdr(dt, 2'(vc), 16'd8), 3, 1'b0);
            end
            9: begin
               dt = 6'h10 + 6'($urandom_range(0, 15));
               sendAndCheck("rnd_otherdt", mkHdr(dt, 2'd0, 16'd8), $urandom_range(0, 3), 1'b0);
            end
            default: begin
               np = $urandom_range(1, 6);
               sendAndCheck("rnd_line", mkHdr(6'h2C, 2'd0, 16'(np * 4)),
                            np + 1 + $urandom_range(0, 1), 1'b0);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
